// File: rtl/pe_tx_packetizer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// pe_tx_packetizer
//
// Store-and-forward packet builder placed directly upstream of one PE output
// port of the 2x2 mesh NOC. Words from the processing element are collected
// into a local buffer until the message ends (in_last) or the buffer fills
// (MaxLen). The packet is then injected as one header flit {len, dest}
// followed by len payload flits.
//
// Ports
//   clk, rst_n     single rising-edge clock, asynchronous active-low reset
//   in_valid       PE word valid
//   in_ready       packetizer can accept a word (high only while collecting)
//   in_data        payload word
//   in_last        word closes the current message
//   in_dest        destination node, sampled with the first word of a packet
//   in_vc          virtual channel, sampled with the first word of a packet
//   PE_OutpData    flit towards the NOC (registered)
//   PE_OutpEn      flit valid (registered)
//   PE_OutpReady   NOC accepts the flit
//   PE_OutpSel     virtual channel of the packet in flight (registered)
//   busy           packet is being injected (HEAD or BODY)
//   err_trunc      sticky: a message was split because it exceeded MaxLen
//   pkt_count      packets fully injected, wraps modulo 2^16
// ---------------------------------------------------------------------------
module pe_tx_packetizer #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 2,
  parameter int ViChAddr  = 1,
  parameter int MaxLen    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_last,
  input  logic [AddrWidth-1:0] in_dest,
  input  logic [ViChAddr-1:0]  in_vc,
  output logic [DataWidth-1:0] PE_OutpData,
  output logic                 PE_OutpEn,
  input  logic                 PE_OutpReady,
  output logic [ViChAddr-1:0]  PE_OutpSel,
  output logic                 busy,
  output logic                 err_trunc,
  output logic [15:0]          pkt_count
);

  // The length field fills the header bits above the destination address.
  localparam int LenW  = DataWidth - AddrWidth;
  localparam int IdxW  = (MaxLen > 1) ? $clog2(MaxLen) : 1;
  localparam int Depth = 1 << IdxW;
  localparam logic [LenW-1:0] LastIdx = LenW'(MaxLen - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEAD    = 2'd1,
    BODY    = 2'd2
  } stateT;

  stateT                state, stateNext;
  logic [LenW-1:0]      wrCnt, wrCntNext;
  logic [LenW-1:0]      rdIdx, rdIdxNext;
  logic [LenW-1:0]      len, lenNext;
  logic [AddrWidth-1:0] dest, destNext;
  logic [ViChAddr-1:0]  vc, vcNext;
  logic                 errNext;
  logic [15:0]          pktCountNext;
  logic                 outEnNext;
  logic [DataWidth-1:0] outDataNext;
  logic [ViChAddr-1:0]  outSelNext;
  logic                 bufWe;

  logic [DataWidth-1:0] pktBuf [Depth];

  logic [LenW-1:0]      wrCntInc;
  logic [LenW-1:0]      rdIdxInc;
  logic                 lastFlit;
  logic [AddrWidth-1:0] curDest;
  logic [ViChAddr-1:0]  curVc;

  assign wrCntInc = wrCnt + 1'b1;
  assign rdIdxInc = rdIdx + 1'b1;
  assign lastFlit = (rdIdx == len - 1'b1);

  // The header is built on the closing edge, which may also be the first
  // word of the packet, so the freshly sampled routing fields are bypassed.
  assign curDest = (wrCnt == '0) ? in_dest : dest;
  assign curVc   = (wrCnt == '0) ? in_vc   : vc;

  assign in_ready = (state == COLLECT);
  assign busy     = (state != COLLECT);

  // NOTE: the payload buffer has no reset; every entry is written before it
  // is read, and leaving it out keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (bufWe) begin
      pktBuf[wrCnt[IdxW-1:0]] <= in_data;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      wrCnt       <= '0;
      rdIdx       <= '0;
      len         <= '0;
      dest        <= '0;
      vc          <= '0;
      err_trunc   <= 1'b0;
      pkt_count   <= '0;
      PE_OutpEn   <= 1'b0;
      PE_OutpData <= '0;
      PE_OutpSel  <= '0;
    end else begin
      state       <= stateNext;
      wrCnt       <= wrCntNext;
      rdIdx       <= rdIdxNext;
      len         <= lenNext;
      dest        <= destNext;
      vc          <= vcNext;
      err_trunc   <= errNext;
      pkt_count   <= pktCountNext;
      PE_OutpEn   <= outEnNext;
      PE_OutpData <= outDataNext;
      PE_OutpSel  <= outSelNext;
    end
  end

  // Next-state and next-output decode. The NOC-facing outputs are registered,
  // so the flit for the following cycle is selected here, one edge ahead.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    stateNext    = state;
    wrCntNext    = wrCnt;
    rdIdxNext    = rdIdx;
    lenNext      = len;
    destNext     = dest;
    vcNext       = vc;
    errNext      = err_trunc;
    pktCountNext = pkt_count;
    outEnNext    = PE_OutpEn;
    outDataNext  = PE_OutpData;
    outSelNext   = PE_OutpSel;
    bufWe        = 1'b0;

    unique case (state)
      COLLECT: begin
        if (in_valid) begin
          bufWe     = 1'b1;
          wrCntNext = wrCntInc;
          destNext  = curDest;
          vcNext    = curVc;
          if (in_last || (wrCnt == LastIdx)) begin
            lenNext     = wrCntInc;
            stateNext   = HEAD;
            outEnNext   = 1'b1;
            outDataNext = {wrCntInc, curDest};
            outSelNext  = curVc;
            // A full buffer without in_last splits the message; the
            // remaining words start a fresh packet to the same consumer.
            if (!in_last) begin
              errNext = 1'b1;
            end
          end
        end
      end

      HEAD: begin
        if (PE_OutpReady) begin
          rdIdxNext   = '0;
          stateNext   = BODY;
          outDataNext = pktBuf[0];
        end
      end

      BODY: begin
        if (PE_OutpReady) begin
          if (lastFlit) begin
            stateNext    = COLLECT;
            wrCntNext    = '0;
            pktCountNext = pkt_count + 16'd1;
            outEnNext    = 1'b0;
          end else begin
            rdIdxNext   = rdIdxInc;
            outDataNext = pktBuf[rdIdxInc[IdxW-1:0]];
          end
        end
      end

      default: begin
        stateNext = COLLECT;
        outEnNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_tx_packetizer.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_pe_tx_packetizer
//
// Table-driven bench: each record holds a message (words, dest, vc), a
// PE_OutpReady pattern and the hand-computed flit sequence, packet count and
// truncation flag expected afterwards. Hand-written sequences cover reset
// values, back-to-back timing, reset mid-packet and the packet counter wrap.
// ---------------------------------------------------------------------------
module tb_pe_tx_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [1:0]  in_dest;
  logic        in_vc;
  logic [7:0]  PE_OutpData;
  logic        PE_OutpEn;
  logic        PE_OutpReady;
  logic        PE_OutpSel;
  logic        busy;
  logic        err_trunc;
  logic [15:0] pkt_count;

  always #5 clk = ~clk;

  pe_tx_packetizer #(
    .DataWidth(8),
    .AddrWidth(2),
    .ViChAddr (1),
    .MaxLen   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_dest     (in_dest),
    .in_vc       (in_vc),
    .PE_OutpData (PE_OutpData),
    .PE_OutpEn   (PE_OutpEn),
    .PE_OutpReady(PE_OutpReady),
    .PE_OutpSel  (PE_OutpSel),
    .busy        (busy),
    .err_trunc   (err_trunc),
    .pkt_count   (pkt_count)
  );

  // Words and flits are packed LSB-first: element 0 sits in bits [7:0].
  typedef struct packed {
    logic [3:0]  nWords;
    logic [95:0] words;
    logic [1:0]  dest;
    logic        vc;
    logic [15:0] readyPat;
    logic [4:0]  nFlits;
    logic [95:0] expFlits;
    logic        expSel;
    logic [15:0] expPkt;
    logic        expErr;
  } tVec;

  int nPass   = 0;
  int nChecks = 0;
  int holdErr = 0;
  int busyReadyErr = 0;

  logic       monEn = 1'b0;
  logic [8:0] flitQ [$];
  logic       prevPending = 1'b0;
  logic [8:0] prevFlit = '0;

  tVec vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tVec mkVec(input logic [3:0] n, input logic [95:0] w,
                                input logic [1:0] d, input logic vcIn,
                                input logic [15:0] rp, input logic [4:0] nf,
                                input logic [95:0] ef, input logic es,
                                input logic [15:0] ep, input logic ee);
    tVec v;
    v.nWords   = n;
    v.words    = w;
    v.dest     = d;
    v.vc       = vcIn;
    v.readyPat = rp;
    v.nFlits   = nf;
    v.expFlits = ef;
    v.expSel   = es;
    v.expPkt   = ep;
    v.expErr   = ee;
    return v;
  endfunction

  // Flit monitor: a flit seen valid and accepted at the falling edge
  // transfers on the next rising edge. Also watches the valid-hold rule.
  always @(negedge clk) begin
    if (monEn && rst_n) begin
      if (prevPending && (!PE_OutpEn || ({PE_OutpSel, PE_OutpData} != prevFlit)))
        holdErr <= holdErr + 1;
      if (busy && in_ready)
        busyReadyErr <= busyReadyErr + 1;
      if (PE_OutpEn && PE_OutpReady)
        flitQ.push_back({PE_OutpSel, PE_OutpData});
      prevPending <= PE_OutpEn && !PE_OutpReady;
      prevFlit    <= {PE_OutpSel, PE_OutpData};
    end else begin
      prevPending <= 1'b0;
    end
  end

  task automatic waitInReady();
    int b;
    b = 0;
    while (!in_ready && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 200) check("in_ready_wait_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic sendWords(input tVec v);
    logic [95:0] w;
    w = v.words;
    for (int i = 0; i < int'(v.nWords); i++) begin
      in_valid = 1'b1;
      in_data  = w[7:0];
      in_last  = (i == int'(v.nWords) - 1);
      in_dest  = v.dest;
      in_vc    = v.vc;
      waitInReady();
      @(posedge clk);
      #1;
      w = w >> 8;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    // Header must be valid in the cycle right after the closing word.
    @(negedge clk);
    check("hdr_latency", 32'(PE_OutpEn), 32'd1);
  endtask

  task automatic driveReady(input tVec v);
    logic [15:0] pat;
    int b;
    pat = v.readyPat;
    b = 0;
    while (!PE_OutpEn && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    b = 0;
    while (flitQ.size() < int'(v.nFlits) && b < 400) begin
      PE_OutpReady = pat[0];
      pat = {1'b1, pat[15:1]};
      @(posedge clk);
      #1;
      b++;
    end
    PE_OutpReady = 1'b1;
  endtask

  task automatic runVector(input int idx, input tVec v);
    logic [95:0] f;
    flitQ.delete();
    monEn = 1'b1;
    fork
      sendWords(v);
      driveReady(v);
    join
    monEn = 1'b0;
    check($sformatf("v%0d flit_count", idx), 32'(flitQ.size()), 32'(v.nFlits));
    f = v.expFlits;
    for (int k = 0; k < int'(v.nFlits); k++) begin
      if (k < flitQ.size())
        check($sformatf("v%0d flit%0d {sel,data}", idx, k), 32'(flitQ[k]), 32'({v.expSel, f[7:0]}));
      f = f >> 8;
    end
    check($sformatf("v%0d pkt_count", idx), 32'(pkt_count), 32'(v.expPkt));
    check($sformatf("v%0d err_trunc", idx), 32'(err_trunc), 32'(v.expErr));
    check($sformatf("v%0d in_ready_idle", idx), 32'(in_ready), 32'd1);
    check($sformatf("v%0d busy_idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Stimulus table with hand-computed flits (header = len<<2 | dest).
    vecs[0] = mkVec(4'd3, 96'({8'h33, 8'h22, 8'h11}), 2'd2, 1'b1, 16'hFFFF,
                    5'd4, 96'({8'h33, 8'h22, 8'h11, 8'h0E}), 1'b1, 16'd1, 1'b0);
    vecs[1] = mkVec(4'd3, 96'({8'h33, 8'h22, 8'h11}), 2'd2, 1'b1, 16'hFFE9,
                    5'd4, 96'({8'h33, 8'h22, 8'h11, 8'h0E}), 1'b1, 16'd2, 1'b0);
    vecs[2] = mkVec(4'd8, 96'({8'hC7, 8'hC6, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}),
                    2'd0, 1'b1, 16'hAAAA, 5'd9,
                    96'({8'hC7, 8'hC6, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0, 8'h20}),
                    1'b1, 16'd3, 1'b0);
    vecs[3] = mkVec(4'd10, 96'({8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03,
                                8'h02, 8'h01}),
                    2'd1, 1'b0, 16'hFFFF, 5'd12,
                    {8'h0A, 8'h09, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03,
                     8'h02, 8'h01, 8'h21},
                    1'b0, 16'd5, 1'b1);
    vecs[4] = mkVec(4'd2, 96'({8'h32, 8'h31}), 2'd2, 1'b1, 16'hFFFF,
                    5'd3, 96'({8'h32, 8'h31, 8'h0A}), 1'b1, 16'd1, 1'b0);
    vecs[5] = mkVec(4'd3, 96'({8'h99, 8'h88, 8'h77}), 2'd1, 1'b1, 16'hFFFF,
                    5'd4, 96'({8'h99, 8'h88, 8'h77, 8'h0D}), 1'b1, 16'd0, 1'b0);
    vecs[6] = mkVec(4'd1, 96'({8'hE1}), 2'd2, 1'b0, 16'hFFFF,
                    5'd2, 96'({8'hE1, 8'h06}), 1'b0, 16'd0, 1'b0);

    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    in_dest      = '0;
    in_vc        = 1'b0;
    PE_OutpReady = 1'b1;

    // Reset values while reset is held.
    #12;
    check("rst PE_OutpEn", 32'(PE_OutpEn), 32'd0);
    check("rst PE_OutpData", 32'(PE_OutpData), 32'd0);
    check("rst PE_OutpSel", 32'(PE_OutpSel), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst err_trunc", 32'(err_trunc), 32'd0);
    check("rst pkt_count", 32'(pkt_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst in_ready", 32'(in_ready), 32'd1);

    // Single packet, backpressure, exact-MaxLen, truncation.
    for (int i = 0; i < 4; i++) runVector(i, vecs[i]);
    check("hold_stable", 32'(holdErr), 32'd0);
    check("in_ready_low_while_busy", 32'(busyReadyErr), 32'd0);

    // One-word packets back to back: second accepted right after the first
    // packet's last transfer.
    check("b2b in_ready0", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1; in_dest = 2'd3; in_vc = 1'b0;
    @(posedge clk);
    #1;
    in_data = 8'hA5; in_dest = 2'd0;
    @(negedge clk);
    check("b2b hdr1", 32'({PE_OutpEn, PE_OutpSel, PE_OutpData}), 32'({1'b1, 1'b0, 8'h07}));
    check("b2b in_ready hdr1", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("b2b pay1", 32'({PE_OutpEn, PE_OutpData}), 32'({1'b1, 8'h5A}));
    check("b2b in_ready pay1", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("b2b in_ready after", 32'(in_ready), 32'd1);
    check("b2b en after", 32'(PE_OutpEn), 32'd0);
    check("b2b pkt_count1", 32'(pkt_count), 32'd6);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check("b2b hdr2", 32'({PE_OutpEn, PE_OutpData}), 32'({1'b1, 8'h04}));
    @(negedge clk);
    check("b2b pay2", 32'({PE_OutpEn, PE_OutpData}), 32'({1'b1, 8'hA5}));
    @(negedge clk);
    check("b2b en end", 32'(PE_OutpEn), 32'd0);
    check("b2b pkt_count2", 32'(pkt_count), 32'd7);

    // Reset in the middle of BODY.
    sendWords(vecs[5]);
    check("midrst hdr", 32'(PE_OutpData), 32'h0D);
    @(negedge clk);
    check("midrst pay0", 32'(PE_OutpData), 32'h77);
    @(negedge clk);
    check("midrst pay1", 32'({PE_OutpEn, PE_OutpData}), 32'({1'b1, 8'h88}));
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst PE_OutpEn", 32'(PE_OutpEn), 32'd0);
    check("midrst PE_OutpData", 32'(PE_OutpData), 32'd0);
    check("midrst PE_OutpSel", 32'(PE_OutpSel), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst err_trunc", 32'(err_trunc), 32'd0);
    check("midrst pkt_count", 32'(pkt_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runVector(4, vecs[4]);

    // Packet counter wrap from 0xFFFF to 0x0000.
    force dut.pkt_count = 16'hFFFF;
    #1;
    release dut.pkt_count;
    #1;
    check("wrap preload", 32'(pkt_count), 32'h0000FFFF);
    runVector(6, vecs[6]);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
